// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, FREEZE = 2'd2, FLUSH = 2'd3} hz_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the ID instruction and the load in EX
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       hazard
);
  always_comb
    hazard = ex_memread && ex_rt != REG_ZERO && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline; HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_FREEZE   = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             freeze_timeout,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
`endif
  output logic [1:0]       state_o
);
  localparam int FW = $clog2(MAX_FREEZE + 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FRZ_MAX = FW'(MAX_FREEZE);
  hz_state_t state_q, state_d;
  logic [2:0] fl_q, fl_d;
  logic [FW-1:0] frz_q, frz_d;
  logic tmo_q, tmo_d;
  logic hazard;
  hazard_detect u_hd (
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .hazard(hazard)
  );
  always_comb begin
    state_d = state_q;
    fl_d = fl_q;
    frz_d = frz_q;
    pc_write = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_flush = 1'b0;
    case (state_q)
      FREEZE: begin
        pc_write = 1'b0;
        ifid_write = 1'b0;
        state_d = ext_stall ? FREEZE : RUN;
        frz_d = !ext_stall ? '0 : frz_q == FRZ_MAX ? frz_q : frz_q + 1'b1;
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_flush = mem_branch_taken;
        pc_write = mem_branch_taken || !ext_stall;
        fl_d = mem_branch_taken ? FL_RELOAD : ext_stall ? fl_q : fl_q - 3'd1;
        state_d = (!mem_branch_taken && !ext_stall && fl_q == 3'd1) ? RUN : FLUSH;
      end
      default: begin
        state_d = RUN;
        if (mem_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exmem_flush = 1'b1;
          fl_d = FL_RELOAD;
          state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
        end else if (ext_stall) begin
          pc_write = 1'b0;
          ifid_write = 1'b0;
          frz_d = FW'(1);
          state_d = FREEZE;
        end else if (hazard && state_q == RUN) begin
          // the bubble enters EX this cycle, so LOAD_STALL never re-stalls
          pc_write = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          state_d = LOAD_STALL;
        end
      end
    endcase
    tmo_d = tmo_q || frz_d == FRZ_MAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fl_q <= '0;
      frz_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q <= fl_d;
      frz_q <= frz_d;
      tmo_q <= tmo_d;
    end
  end
  assign freeze_timeout = tmo_q;
  assign state_o = state_q;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, freeze_cnt_q, freeze_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(state_q == LOAD_STALL && !(&stall_cnt_q));
    flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush && !(&flush_cnt_q));
    freeze_cnt_d = freeze_cnt_q + CNT_W'(state_q == FREEZE && !(&freeze_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, freeze/reset sequences and random run against a reference model
module tb_pipe_hazard_ctrl;
  localparam int FC = 2;
  localparam int MF = 255;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0, ext_stall = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze_timeout;
  logic [1:0] state_o;
  int n_cmp = 0, n_bad = 0;
  int m_flush = 0, m_frz = 0;
  bit m_frozen = 0, m_stalled = 0, m_tmo = 0;
  typedef struct packed {
    logic r; logic [4:0] rs, rt; logic ur, mr; logic [4:0] ert; logic br, ext;
    logic [4:0] eo; logic [1:0] es;
  } vec_t;
  vec_t tv[$];
  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_FREEZE(MF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .ext_stall(ext_stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .freeze_timeout(freeze_timeout), .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(int r, int rs, int rt, int ur, int mr, int ert, int br, int ext, int eo, int es);
    v.r = r[0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.ur = ur[0]; v.mr = mr[0];
    v.ert = ert[4:0]; v.br = br[0]; v.ext = ext[0]; v.eo = eo[4:0]; v.es = es[1:0];
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit hz();
    return ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction
  task automatic model_out(output logic [4:0] o, output logic [1:0] s);
    if (m_frozen) begin o = 5'b00000; s = 2; end
    else if (m_flush > 0) begin o = {mem_branch_taken | ~ext_stall, 3'b111, mem_branch_taken}; s = 3; end
    else begin
      s = m_stalled ? 2'd1 : 2'd0;
      o = mem_branch_taken ? 5'b11111 : ext_stall ? 5'b00000 : (hz() && !m_stalled) ? 5'b00010 : 5'b11000;
    end
  endtask
  task automatic model_step();
    bit nst = 0;
    if (rst) begin
      m_flush = 0; m_frz = 0; m_frozen = 0; m_stalled = 0; m_tmo = 0;
      return;
    end
    if (m_frozen) begin
      if (ext_stall) m_frz = (m_frz + 1 > MF) ? MF : m_frz + 1;
      else begin m_frozen = 0; m_frz = 0; end
    end else if (m_flush > 0) begin
      if (mem_branch_taken) m_flush = FC - 1;
      else if (!ext_stall) m_flush--;
    end else if (mem_branch_taken) m_flush = FC - 1;
    else if (ext_stall) begin m_frozen = 1; m_frz = 1; end
    else if (hz() && !m_stalled) nst = 1;
    m_stalled = nst;
    if (m_frozen && m_frz == MF) m_tmo = 1;
  endtask
  task automatic cyc(input string tag, input bit use_tab, input logic [4:0] eo, input logic [1:0] es);
    logic [4:0] o;
    logic [1:0] s;
    #1;
    model_out(o, s);
    chk({tag, "_outs"}, {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}, o);
    chk({tag, "_state"}, state_o, s);
    chk({tag, "_tmo"}, freeze_timeout, m_tmo);
    if (use_tab) begin
      chk({tag, "_tab_outs"}, {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}, eo);
      chk({tag, "_tab_state"}, state_o, es);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic set_in(input vec_t t);
    rst = t.r; id_rs = t.rs; id_rt = t.rt; id_uses_rt = t.ur; ex_memread = t.mr;
    ex_rt = t.ert; mem_branch_taken = t.br; ext_stall = t.ext;
  endtask
  initial begin
    int burst = 0;
    // r rs rt ur mr ert br ext | {pc,iw,iff,xf,mf} state
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 2, 0, 0, 1, 2, 0, 0, 'b00010, 0));
    tv.push_back(v(0, 2, 0, 0, 1, 2, 0, 0, 'b11000, 1));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 1, 5, 0, 1, 5, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 1, 5, 1, 1, 5, 0, 0, 'b00010, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 1));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 'b11111, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11110, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 2, 0, 0, 1, 2, 1, 1, 'b11111, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11110, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 'b00000, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b00000, 2));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 'b11111, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 'b01110, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11110, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 'b11111, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 'b11111, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11110, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 'b11111, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b11110, 3));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b11000, 0));
    @(negedge clk);
    @(negedge clk);
    foreach (tv[i]) begin
      set_in(tv[i]);
      cyc($sformatf("vec%0d", i), 1'b1, tv[i].eo, tv[i].es);
    end
    set_in(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 300; k++) begin
      cyc($sformatf("frz%0d", k), 1'b0, '0, '0);
      if (k == MF - 1) chk("tmo_before_max", freeze_timeout, 0);
      if (k == MF) chk("tmo_at_max", freeze_timeout, 1);
    end
    ext_stall = 1'b0;
    cyc("frz_exit", 1'b1, 5'b00000, 2'd2);
    chk("tmo_sticky", freeze_timeout, 1);
    cyc("frz_run", 1'b1, 5'b11000, 2'd0);
    rst = 1'b1;
    cyc("tmo_rst", 1'b0, '0, '0);
    rst = 1'b0;
    chk("tmo_cleared", freeze_timeout, 0);
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      mem_branch_taken = $urandom_range(0, 9) == 0;
      if (burst > 0) begin ext_stall = 1'b1; burst--; end
      else begin
        ext_stall = $urandom_range(0, 19) == 0;
        if (ext_stall) burst = $urandom_range(0, 5);
      end
      ex_memread = $urandom_range(0, 1) == 1;
      id_uses_rt = $urandom_range(0, 1) == 1;
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      cyc("rnd", 1'b0, '0, '0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives write-enables and bubble-insertion for PC, IF/ID and ID/EX (buffer2-style) registers.
- Handles load-use hazards, taken-branch flush and external memory-wait freeze.
- Sits in the ID stage beside the hazard-detect comparators; also raises a sticky timeout if a freeze never ends.

Parameters:
- FLUSH_CYCLES, 2, cycles ifid_flush/idex_flush stay asserted after a taken branch (1..7).
- MAX_FREEZE, 255, ext_stall cycles tolerated before freeze_timeout sets.
- CNT_W, 16, width of optional perf counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq)
- ex_memread  in  1  memread_out of ID/EX register
- ex_rt  in  5  rt destination held in ID/EX register
- mem_branch_taken  in  1  branch resolved taken in MEM (branch & zero)
- ext_stall  in  1  data/instruction memory not ready
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_flush  out  1  ID/EX loads zero control bits (bubble)
- exmem_flush  out  1  EX/MEM loads zero control bits
- freeze_timeout  out  1  sticky error flag
- state_o  out  2  current FSM state (debug)

Behaviour:
- States, 2-bit encoded: RUN=0, LOAD_STALL=1, FREEZE=2, FLUSH=3.
- Reset (sync, rst=1 at edge):
  - state RUN, flush counter 0, freeze counter 0, freeze_timeout 0, perf counters 0.
  - Outputs while in RUN: pc_write=1, ifid_write=1, all flushes 0.
- Outputs are combinational from state plus current inputs; state and counters are registered.
- Load-use hazard: ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Input priority within a cycle: mem_branch_taken > ext_stall > load-use hazard.
- RUN:
  - Branch taken: ifid_flush=1, idex_flush=1, exmem_flush=1 this cycle; pc_write=1 so the target loads. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else ext_stall: pc_write=0, ifid_write=0, no flushes; go to FREEZE, freeze counter=1.
  - Else hazard: pc_write=0, ifid_write=0, idex_flush=1; go to LOAD_STALL.
- LOAD_STALL:
  - Exactly one cycle. Outputs are the RUN defaults (the bubble has already entered EX). Go to RUN.
  - Branch taken overrides as in RUN. ext_stall takes the FREEZE path.
- FREEZE:
  - pc_write=0, ifid_write=0, all flushes 0.
  - Freeze counter increments (saturating) each cycle ext_stall=1.
  - When the counter reaches MAX_FREEZE, freeze_timeout sets and stays set until rst.
  - When ext_stall=0, go to RUN next cycle and clear the counter.
  - mem_branch_taken during FREEZE is ignored; it is still stable in MEM when the freeze ends.
- FLUSH:
  - ifid_flush=1, idex_flush=1, exmem_flush=0, pc_write=1.
  - Counter decrements each cycle; at 1 go to RUN.
  - A new mem_branch_taken reloads the counter with FLUSH_CYCLES-1 and asserts exmem_flush.
  - ext_stall in FLUSH: hold the counter, pc_write=0; flushes stay asserted.
- rst mid-operation: next state is RUN regardless of current state; in-progress flush or stall is abandoned.
- ex_rt==0 never causes a stall.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds outputs stall_cnt, flush_cnt, freeze_cnt (CNT_W each).
  - Each counts cycles spent in LOAD_STALL, FLUSH (including RUN flush cycles) and FREEZE respectively.
  - Counters saturate at all-ones and clear on rst.
- Undefined: these ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - hz_state_t enum (RUN, LOAD_STALL, FREEZE, FLUSH).
  - REG_ZERO=5'd0.
  - NOP instruction constant (32'h0).
- One sub-module, hazard_detect: the pure combinational load-use comparator. The FSM and counters stay in the top module.

Test Plan:
- Load-use: lw $2 in EX (ex_memread=1, ex_rt=2), ID add with rs=2 → one cycle of pc_write=0, ifid_write=0, idex_flush=1, state LOAD_STALL, then RUN with no repeat stall.
- Zero register: ex_memread=1, ex_rt=0, id_rs=0 → no stall, pc_write stays 1.
- Taken branch, FLUSH_CYCLES=2: mem_branch_taken=1 → all three flushes in cycle 0, ifid/idex flush in cycle 1, RUN in cycle 2.
- Simultaneous branch + hazard + ext_stall: branch wins → flush pattern, no LOAD_STALL or FREEZE entry.
- Freeze: ext_stall high 300 cycles with MAX_FREEZE=255 → pc_write=0 throughout, freeze_timeout rises at count 255 and stays 1 after ext_stall drops; RUN the next cycle.
- Reset in FLUSH with counter=1 → next cycle state RUN, all flushes 0, freeze_timeout 0, perf counters 0 (with HAZARD_PERF_EN).
